instr_issue: RTL and testbench

//  Initiator side of the per-branch valid/ready commit protocol. On each sample_tick it walks
//  the block program from block 0 to program_length-1 and fetches each instruction word. It

---
 rtl/instr_issue_pkg.sv | 30 +++
 rtl/instr_issue_branch_sel.sv | 11 +
 rtl/instr_issue.sv | 165 ++++++++++++++++
 tb/tb_instr_issue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction issue path: branch indices, commit id width,
// opcode field location and the opcode-to-branch map used by issue and branch units.
package instr_issue_pkg;

   localparam int N_INSTR_BRANCHES = 4;
   localparam int BRANCH_W         = $clog2(N_INSTR_BRANCHES);
   localparam int COMMIT_ID_WIDTH  = 4;

   localparam logic [BRANCH_W-1:0] INSTR_BRANCH_ALU  = 2'd0;
   localparam logic [BRANCH_W-1:0] INSTR_BRANCH_MAC  = 2'd1;
   localparam logic [BRANCH_W-1:0] INSTR_BRANCH_MEM  = 2'd2;
   localparam logic [BRANCH_W-1:0] INSTR_BRANCH_CTRL = 2'd3;

   localparam int OPCODE_LSB   = 26;
   localparam int OPCODE_WIDTH = 6;

   // The two opcode MSBs select the owning execution branch.
   function automatic logic [BRANCH_W-1:0] opcode_to_branch(input logic [OPCODE_WIDTH-1:0] opcode);
      logic [BRANCH_W-1:0] br;
      case (opcode[OPCODE_WIDTH-1 -: 2])
         2'b00:   br = INSTR_BRANCH_ALU;
         2'b01:   br = INSTR_BRANCH_MAC;
         2'b10:   br = INSTR_BRANCH_MEM;
         2'b11:   br = INSTR_BRANCH_CTRL;
         default: br = INSTR_BRANCH_ALU;
      endcase
      return br;
   endfunction

endpackage

// File: rtl/instr_issue_branch_sel.sv
// Combinational opcode -> execution branch decoder, shared with the branch units.
module instr_branch_sel
   import instr_issue_pkg::*;
(
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output logic [BRANCH_W-1:0]     branch
);

   assign branch = opcode_to_branch(opcode);

endmodule

// File: rtl/instr_issue.sv
// Walks the block program once per sample tick and offers each instruction, tagged with a
// sequential commit id, to its owning branch under a bounded in-flight window.
module instr_issue
   import instr_issue_pkg::*;
#(
   parameter int data_width   = 16,
   parameter int n_blocks     = 256,
   parameter int instr_width  = 32,
   parameter int max_inflight = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          sample_tick,
   input  logic [$clog2(n_blocks):0]     program_length,
   output logic [$clog2(n_blocks)-1:0]   instr_addr,
   output logic                          instr_rd_en,
   input  logic [instr_width-1:0]        instr_data,
   input  logic [COMMIT_ID_WIDTH-1:0]    next_commit_id,
   output logic [N_INSTR_BRANCHES-1:0]   out_valid,
   input  logic [N_INSTR_BRANCHES-1:0]   out_ready,
   output logic [$clog2(n_blocks)-1:0]   out_block,
   output logic [instr_width-1:0]        out_instr,
   output logic [COMMIT_ID_WIDTH-1:0]    out_commit_id,
   output logic                          program_done,
   output logic                          busy,
   output logic                          overrun
);

   localparam int BW   = $clog2(n_blocks);
   localparam int PL_W = BW + 1;
   localparam logic [COMMIT_ID_WIDTH:0] MAX_INFL = (COMMIT_ID_WIDTH+1)'(max_inflight);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_LATCH = 2'd2,
      ST_ISSUE = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic [BW-1:0]              block_q, block_d;
   logic [COMMIT_ID_WIDTH-1:0] issue_id_q, issue_id_d;
   logic [instr_width-1:0]     hold_instr_q, hold_instr_d;
   logic [BW-1:0]              hold_block_q, hold_block_d;
   logic [COMMIT_ID_WIDTH-1:0] hold_id_q, hold_id_d;
   logic [BRANCH_W-1:0]        branch_q, branch_d;
   logic                       done_q, done_d;
   logic                       overrun_q, overrun_d;

   logic [BRANCH_W-1:0]        dec_branch_s;
   logic [COMMIT_ID_WIDTH-1:0] id_gap_s;
   logic                       window_ok_s;
   logic                       transfer_s;
   logic                       last_block_s;
   logic                       busy_s;
   logic [data_width-1:0]      unused_sample_s;

   // Sample width only matters to the branch datapaths downstream.
   assign unused_sample_s = '0;

   instr_branch_sel u_branch_sel (
      .opcode (instr_data[OPCODE_LSB +: OPCODE_WIDTH]),
      .branch (dec_branch_s)
   );

   // Modular distance stays correct across id wrap since the window is at most half the id space.
   assign id_gap_s     = issue_id_q - next_commit_id;
   assign window_ok_s  = ({1'b0, id_gap_s} < MAX_INFL);
   assign last_block_s = ({1'b0, block_q} == (program_length - PL_W'(1)));
   assign busy_s       = (state_q != ST_IDLE);
   assign transfer_s   = |(out_valid & out_ready);

   always_comb begin
      out_valid = '0;
      if ((state_q == ST_ISSUE) && enable && window_ok_s) begin
         out_valid[branch_q] = 1'b1;
      end else begin
         out_valid = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      block_d      = block_q;
      issue_id_d   = issue_id_q;
      hold_instr_d = hold_instr_q;
      hold_block_d = hold_block_q;
      hold_id_d    = hold_id_q;
      branch_d     = branch_q;
      done_d       = 1'b0;
      overrun_d    = overrun_q | (sample_tick & busy_s);
      if (enable) begin
         case (state_q)
            ST_IDLE: begin
               if (sample_tick && (program_length != '0)) begin
                  block_d = '0;
                  state_d = ST_READ;
               end else begin
                  done_d = sample_tick;
               end
            end
            ST_READ: state_d = ST_LATCH;
            ST_LATCH: begin
               hold_instr_d = instr_data;
               hold_block_d = block_q;
               hold_id_d    = issue_id_q;
               branch_d     = dec_branch_s;
               state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
               if (transfer_s) begin
                  issue_id_d = issue_id_q + COMMIT_ID_WIDTH'(1);
                  if (last_block_s) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     block_d = block_q + BW'(1);
                     state_d = ST_READ;
                  end
               end else begin
                  state_d = ST_ISSUE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         block_q      <= '0;
         issue_id_q   <= '0;
         hold_instr_q <= '0;
         hold_block_q <= '0;
         hold_id_q    <= '0;
         branch_q     <= '0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         block_q      <= block_d;
         issue_id_q   <= issue_id_d;
         hold_instr_q <= hold_instr_d;
         hold_block_q <= hold_block_d;
         hold_id_q    <= hold_id_d;
         branch_q     <= branch_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign instr_addr    = block_q;
   assign instr_rd_en   = (state_q == ST_READ) & enable;
   assign out_block     = hold_block_q;
   assign out_instr     = hold_instr_q;
   assign out_commit_id = hold_id_q;
   assign program_done  = done_q;
   assign busy          = busy_s;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model of the issue protocol.
module tb_instr_issue;

   localparam int MAX_INFL = 2;
   localparam int ID_MOD   = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        sample_tick = 1'b0;
   logic [8:0]  program_length = 9'd0;
   logic [7:0]  instr_addr;
   logic        instr_rd_en;
   logic [31:0] instr_data = 32'd0;
   logic [3:0]  next_commit_id = 4'd0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 4'd0;
   logic [7:0]  out_block;
   logic [31:0] out_instr;
   logic [3:0]  out_commit_id;
   logic        program_done, busy, overrun;

   instr_issue #(.data_width(16), .n_blocks(256), .instr_width(32), .max_inflight(MAX_INFL)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
      .program_length(program_length), .instr_addr(instr_addr), .instr_rd_en(instr_rd_en),
      .instr_data(instr_data), .next_commit_id(next_commit_id), .out_valid(out_valid),
      .out_ready(out_ready), .out_block(out_block), .out_instr(out_instr),
      .out_commit_id(out_commit_id), .program_done(program_done), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   int total = 0, bad = 0;
   int commit_mode = 0, retired = 0;
   int m_active = 0, m_k = 0, m_phase = 0, m_id = 0, m_done = 0, m_over = 0, m_xfers = 0;
   int dut_xfers = 0, done_cnt = 0;
   int obs_id[$], obs_blk[$];

   // Program memory: data returned the cycle after a read strobe.
   always @(posedge clk) begin
      if (instr_rd_en) instr_data <= mem[instr_addr];
   end

   function automatic int branch_of(input logic [31:0] w);
      int op;
      op = int'(w[31:26]);
      if (op < 16) return 0;
      else if (op < 32) return 1;
      else if (op < 48) return 2;
      else return 3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         step(1);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic reset_dut();
      reset = 1'b1; sample_tick = 1'b0; enable = 1'b1; out_ready = 4'd0;
      step(2);
      reset = 1'b0;
      obs_id.delete(); obs_blk.delete(); done_cnt = 0;
   endtask

   task automatic start_sample(input int len);
      program_length = 9'(len);
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
   endtask

   // Commit master: retires issued ids according to commit_mode.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (reset) retired = 0;
         else if (retired < m_id) begin
            case (commit_mode)
               1: retired = m_id;
               2: if ($urandom_range(9) < 4) retired++;
               3: begin retired++; commit_mode = 0; end
               default: ;
            endcase
         end
         next_commit_id = 4'(retired % ID_MOD);
      end
   end

   // Reference model and per-cycle comparison, evaluated mid-cycle with inputs stable.
   initial begin
      logic [3:0] exp_valid;
      int gap, nd, mx;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_valid = 4'd0;
         gap = ((m_id % ID_MOD) - int'(next_commit_id) + ID_MOD) % ID_MOD;
         if (m_active != 0 && m_phase == 2 && enable && gap < MAX_INFL)
            exp_valid[branch_of(mem[m_k])] = 1'b1;
         check("valid", 32'(out_valid), 32'(exp_valid));
         check("rd_en", 32'(instr_rd_en), 32'(m_active != 0 && m_phase == 0 && enable));
         if (m_active != 0 && m_phase == 0 && enable) check("addr", 32'(instr_addr), 32'(m_k));
         check("busy", 32'(busy), 32'(m_active));
         check("done", 32'(program_done), 32'(m_done));
         check("overrun", 32'(overrun), 32'(m_over));
         if (exp_valid != 4'd0) begin
            check("bus_block", 32'(out_block), 32'(m_k));
            check("bus_instr", out_instr, mem[m_k]);
            check("bus_id", 32'(out_commit_id), 32'(m_id % ID_MOD));
         end
         if (!reset && (out_valid & out_ready) != 4'd0) begin
            obs_id.push_back(int'(out_commit_id));
            obs_blk.push_back(int'(out_block));
            dut_xfers++;
         end
         if (program_done) done_cnt++;
         mx = ((exp_valid & out_ready) != 4'd0) ? 1 : 0;
         if (reset) begin
            m_active = 0; m_k = 0; m_phase = 0; m_id = 0; m_done = 0; m_over = 0;
         end else begin
            nd = 0;
            if (sample_tick && m_active != 0) m_over = 1;
            if (enable) begin
               if (m_active == 0) begin
                  if (sample_tick) begin
                     if (program_length == 9'd0) nd = 1;
                     else begin m_active = 1; m_k = 0; m_phase = 0; end
                  end
               end else if (m_phase < 2) m_phase++;
               else if (mx != 0) begin
                  m_id++; m_xfers++;
                  if (m_k == int'(program_length) - 1) begin m_active = 0; nd = 1; end
                  else begin m_k++; m_phase = 0; end
               end
            end
            m_done = nd;
         end
      end
   end

   initial begin
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      step(3);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(instr_rd_en), 32'd0);

      // 1: three blocks, immediate commits
      reset_dut(); commit_mode = 1; out_ready = 4'hF;
      start_sample(3);
      cyc = 1;
      while (out_valid == 4'd0 && cyc < 10) begin step(1); cyc++; end
      check("t1_first_valid_cycle", 32'(cyc), 32'd3);
      wait_idle("t1_timeout", 40); step(2);
      check("t1_count", 32'(obs_id.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("t1_id", 32'(obs_id[i]), 32'(i));
         check("t1_blk", 32'(obs_blk[i]), 32'(i));
      end
      check("t1_done_pulses", 32'(done_cnt), 32'd1);

      // 2: MAC branch back-pressured for 5 cycles
      reset_dut(); commit_mode = 1;
      mem[0] = {6'h15, 26'h2ABCDEF};
      out_ready = 4'b1101;
      start_sample(1); step(2);
      check("t2_valid", 32'(out_valid), 32'h2);
      step(5);
      check("t2_valid_held", 32'(out_valid), 32'h2);
      check("t2_instr", out_instr, 32'h56ABCDEF);
      check("t2_block", 32'(out_block), 32'd0);
      check("t2_no_xfer", 32'(obs_id.size()), 32'd0);
      out_ready = 4'hF;
      wait_idle("t2_timeout", 10); step(1);
      check("t2_xfer", 32'(obs_id.size()), 32'd1);

      // 3: window of 2 with commits held
      reset_dut(); commit_mode = 0; out_ready = 4'hF;
      start_sample(3); step(12);
      check("t3_two_xfers", 32'(obs_id.size()), 32'd2);
      check("t3_blocked", 32'(out_valid), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
      commit_mode = 3; step(2);
      check("t3_third", 32'(obs_id.size()), 32'd3);
      check("t3_third_id", 32'(obs_id[2]), 32'd2);
      wait_idle("t3_timeout", 10);

      // 4: id wrap over 20 blocks
      reset_dut(); commit_mode = 1; out_ready = 4'hF;
      start_sample(20);
      wait_idle("t4_timeout", 200); step(2);
      check("t4_count", 32'(obs_id.size()), 32'd20);
      check("t4_id15", 32'(obs_id[15]), 32'd15);
      check("t4_id16_wrap", 32'(obs_id[16]), 32'd0);
      check("t4_id19", 32'(obs_id[19]), 32'd3);
      check("t4_blk19", 32'(obs_blk[19]), 32'd19);

      // 5: tick while busy, then zero-length program
      reset_dut(); commit_mode = 1;
      start_sample(2); step(3);
      sample_tick = 1'b1; step(1); sample_tick = 1'b0;
      check("t5_overrun", 32'(overrun), 32'd1);
      out_ready = 4'hF;
      wait_idle("t5_timeout", 20); step(2);
      check("t5_count", 32'(obs_id.size()), 32'd2);
      check("t5_done", 32'(done_cnt), 32'd1);
      start_sample(0);
      check("t5_len0_done", 32'(program_done), 32'd1);
      check("t5_len0_busy", 32'(busy), 32'd0);
      step(1);
      check("t5_len0_pulse", 32'(program_done), 32'd0);
      check("t5_overrun_sticky", 32'(overrun), 32'd1);

      // 6: enable low mid-ISSUE, then reset mid-READ
      reset_dut(); commit_mode = 1;
      start_sample(1); step(3);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t6_frozen_valid", 32'(out_valid), 32'd0);
         check("t6_frozen_busy", 32'(busy), 32'd1);
      end
      enable = 1'b1; #1;
      check("t6_resume", 32'(out_valid), 32'(4'd1 << branch_of(mem[0])));
      out_ready = 4'hF;
      wait_idle("t6_timeout", 10);
      start_sample(2);
      check("t6_in_read", 32'(instr_rd_en), 32'd1);
      reset = 1'b1; sample_tick = 1'b1; step(1); reset = 1'b0; sample_tick = 1'b0;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_rd", 32'(instr_rd_en), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_over", 32'(overrun), 32'd0);
      check("t6_rst_bus", {out_instr[23:0] ^ out_instr[31:24], out_block}, 32'd0);
      check("t6_rst_id", 32'(out_commit_id), 32'd0);

      // Randomized run against the model
      commit_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         enable = ($urandom_range(9) != 0);
         sample_tick = ($urandom_range(7) == 0);
         out_ready = 4'($urandom);
         if (m_active == 0) program_length = 9'($urandom_range(6));
         reset = ($urandom_range(499) == 0);
         step(1);
      end
      reset = 1'b0; sample_tick = 1'b0;
      step(2);
      check("xfer_count", 32'(dut_xfers), 32'(m_xfers));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
